// File: rtl/dm_pkg.sv
// Shared definitions for the dm_responder load/store responder: FSM encoding,
// default build parameters and the address range limit.
package dm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int DEF_LATENCY     = 2;

    // First illegal byte address for a memory of depth_words 32-bit words.
    function automatic logic [32:0] addr_limit(input int depth_words);
        return 33'(depth_words) * 33'd4;
    endfunction

    localparam logic [32:0] ADDR_LIMIT = addr_limit(DEF_DEPTH_WORDS);

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge: lanes enabled in be_i take wdata_i, the rest keep old_i.
module dm_byte_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) merged_o[8*i +: 8] = wdata_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding load/store responder with a fixed response latency and a
// word-addressed memory that is cleared by reset.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state_o
);

    // Handshakes: a request transfers on a rising edge with req_valid & req_ready;
    // a response transfers on a rising edge with rsp_valid & rsp_ready, and its
    // data/err hold stable while rsp_valid is high and rsp_ready is low.

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = addr_limit(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    dm_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept, enter_resp, mem_write, op_err;
    logic             op_we;
    logic [31:0]      op_addr, op_wdata, op_word, merged_word;
    logic [3:0]       op_be;
    logic [IDX_W-1:0] op_idx;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // With zero latency RESP is entered on the acceptance edge itself, before the
    // capture registers hold the request, so the live request is used instead.
    assign op_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign op_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign op_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign op_be    = (state_q == ST_IDLE) ? req_be    : be_q;

    assign op_idx  = op_addr[IDX_W+1:2];
    assign op_word = mem_q[op_idx];
    assign op_err  = (op_addr[1:0] != 2'b00) || ({1'b0, op_addr} >= LIMIT);

    dm_byte_merge u_merge (
        .old_i    (op_word),
        .wdata_i  (op_wdata),
        .be_i     (op_be),
        .merged_o (merged_word)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            err_d   = op_err;
            rdata_d = (op_err || op_we) ? 32'd0 : op_word;
        end
    end

    assign mem_write = enter_resp && op_we && !op_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
        end else if (mem_write) begin
            mem_q[op_idx] <= merged_word;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a default build (LATENCY=2, 1024 words) and a
// LATENCY=0 build (64 words), both checked against a word/byte memory model.
module tb_dm_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
    localparam int Z_DEPTH = 64;

    logic        clk;
    logic        reset;
    int          cyc;
    int          checks;
    int          errors;

    // default build
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  dbg_state;

    // zero-latency build
    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;
    logic [1:0]  z_dbg_state;

    logic [31:0] model_mem   [DEPTH];
    logic [31:0] model_mem_z [Z_DEPTH];

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .dbg_state_o(dbg_state)
    );

    dm_responder #(.DEPTH_WORDS(Z_DEPTH), .LATENCY(0)) u_dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err), .dbg_state_o(z_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic clear_models();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        for (int i = 0; i < Z_DEPTH; i++) model_mem_z[i] = 32'd0;
    endtask

    // Applies one request to the model memory and returns the expected response.
    task automatic model_op(input bit zero_lat, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output logic [31:0] rdata, output logic err);
        longint depth;
        int idx;
        logic [31:0] word;
        depth = zero_lat ? longint'(Z_DEPTH) : longint'(DEPTH);
        err   = (addr % 4 != 0) || (longint'(addr) >= depth * 4);
        idx   = int'(addr / 4);
        rdata = 32'd0;
        if (!err) begin
            word = zero_lat ? model_mem_z[idx] : model_mem[idx];
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
                if (zero_lat) model_mem_z[idx] = word;
                else          model_mem[idx]   = word;
            end else begin
                rdata = word;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic scramble_inputs();
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom_range(0, 15));
    endtask

    // One full transaction on the default build, with latency, data, hold-stability
    // and handshake checks; req_* inputs are scrambled while the request is in flight.
    task automatic drive_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input int hold,
                             output logic [31:0] got_rdata, output logic got_err);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          k;
        model_op(1'b0, we, addr, wdata, be, exp_rdata, exp_err);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, req_ready);
        end
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            scramble_inputs();
        end while (!rsp_valid && k < 40);
        checks++;
        if (k != LAT + 1) begin
            errors++;
            $display("FAIL latency addr=%h got %0d cycles required %0d", addr, k, LAT + 1);
        end
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        checks++;
        if (rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
            errors++;
            $display("FAIL response we=%b addr=%h got rdata=%h err=%b required rdata=%h err=%b",
                     we, addr, rsp_rdata, rsp_err, exp_rdata, exp_err);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            scramble_inputs();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== got_rdata || rsp_err !== got_err
                || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle=%0d got valid=%b rdata=%h err=%b ready=%b required 1/%h/%b/0",
                         h, rsp_valid, rsp_rdata, rsp_err, req_ready, got_rdata, got_err);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_handshake got valid=%b ready=%b required valid=0 ready=1",
                     rsp_valid, req_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        clear_models();
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b rdata=%h err=%b ready=%b required 0/0/0/1",
                     rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        checks++;
        if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs_z got valid=%b ready=%b required 0/1", z_rsp_valid, z_req_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b required 1", req_ready);
        end
    endtask

    task automatic test_load_after_reset();
        logic [31:0] r;
        logic e;
        drive_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, r, e);
        checks++;
        if (r !== 32'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL load_after_reset got rdata=%h err=%b required 0/0", r, e);
        end
    endtask

    task automatic test_byte_merge();
        logic [31:0] r;
        logic e;
        drive_txn(1'b1, 32'h20, 32'h1234_5678, 4'b1111, 1, r, e);
        drive_txn(1'b1, 32'h20, 32'hAAAA_AAAA, 4'b0101, 0, r, e);
        drive_txn(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, r, e);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_err got %b required 0", e);
        end
        drive_txn(1'b0, 32'h20, 32'h0, 4'hF, 0, r, e);
        checks++;
        if (r !== 32'h12AA_56AA) begin
            errors++;
            $display("FAIL byte_merge got %h required 12aa56aa", r);
        end
    endtask

    task automatic test_errors();
        logic [31:0] r;
        logic e;
        drive_txn(1'b1, 32'h0FFC, 32'hCAFE_F00D, 4'hF, 0, r, e);
        drive_txn(1'b0, 32'h0013, 32'h0, 4'h0, 0, r, e);
        checks++;
        if (r !== 32'd0 || e !== 1'b1) begin
            errors++;
            $display("FAIL misaligned got rdata=%h err=%b required 0/1", r, e);
        end
        drive_txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, r, e);
        checks++;
        if (r !== 32'd0 || e !== 1'b1) begin
            errors++;
            $display("FAIL out_of_range got rdata=%h err=%b required 0/1", r, e);
        end
        drive_txn(1'b1, 32'h0FFD, 32'h1111_1111, 4'hF, 0, r, e);
        drive_txn(1'b1, 32'h1FFC, 32'h2222_2222, 4'hF, 0, r, e);
        drive_txn(1'b0, 32'h0FFC, 32'h0, 4'h0, 0, r, e);
        checks++;
        if (r !== 32'hCAFE_F00D || e !== 1'b0) begin
            errors++;
            $display("FAIL top_word_kept got rdata=%h err=%b required cafef00d/0", r, e);
        end
    endtask

    task automatic test_hold();
        logic [31:0] r;
        logic e;
        drive_txn(1'b1, 32'h44, 32'h5A5A_0F0F, 4'hF, 0, r, e);
        drive_txn(1'b0, 32'h44, 32'h0, 4'h0, 5, r, e);
        checks++;
        if (r !== 32'h5A5A_0F0F) begin
            errors++;
            $display("FAIL hold_load got %h required 5a5a0f0f", r);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        logic e;
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        clear_models();
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_response got %0d valid cycles required 0", seen);
        end
        drive_txn(1'b0, 32'h40, 32'h0, 4'h0, 0, r, e);
        checks++;
        if (r !== 32'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_write got rdata=%h err=%b required 0/0", r, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, addr;
        logic e;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: addr = 32'($urandom_range(0, 4095)) | 32'd1;
                1: addr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
                2: addr = 32'h0FFC;
                default: addr = 32'h80 + 32'($urandom_range(0, 7) * 4);
            endcase
            drive_txn(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), r, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          acc_cyc, prev_cyc, k;
        z_rsp_ready = 1'b1;
        @(negedge clk);
        prev_cyc = 0;
        for (int i = 0; i < 12; i++) begin
            z_req_valid = 1'b1;
            z_req_we    = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            z_req_addr  = (i == 11) ? 32'h100 : 32'($urandom_range(0, 3) * 4);
            z_req_wdata = $urandom;
            z_req_be    = 4'($urandom_range(0, 15));
            k = 0;
            while (!z_req_ready && k < 10) begin
                @(negedge clk);
                k++;
            end
            acc_cyc = cyc;
            model_op(1'b1, z_req_we, z_req_addr, z_req_wdata, z_req_be, exp_rdata, exp_err);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== exp_rdata || z_rsp_err !== exp_err) begin
                errors++;
                $display("FAIL b2b_resp i=%0d got valid=%b rdata=%h err=%b required 1/%h/%b",
                         i, z_rsp_valid, z_rsp_rdata, z_rsp_err, exp_rdata, exp_err);
            end
            if (i > 0) begin
                checks++;
                if (acc_cyc - prev_cyc != 2) begin
                    errors++;
                    $display("FAIL b2b_spacing i=%0d got %0d cycles required 2", i, acc_cyc - prev_cyc);
                end
            end
            prev_cyc = acc_cyc;
            @(negedge clk);
        end
        z_req_valid = 1'b0;
        z_rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- main ----------------
    initial begin
        cyc = 0; checks = 0; errors = 0;
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0;
        z_req_be = 4'd0; z_rsp_ready = 1'b0;
        test_reset();
        test_load_after_reset();
        test_byte_merge();
        test_errors();
        test_hold();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
